channel_err_injector: RTL and testbench

CHANNEL_ERR_INJECTOR -- requirements
Module: channel_err_injector

---
 rtl/channel_err_injector_pkg.sv | 15 +
 rtl/channel_err_injector_if.sv | 13 +
 rtl/channel_err_injector_lfsr16.sv | 24 ++
 rtl/channel_err_injector.sv | 108 ++++++++++
 tb/tb_channel_err_injector.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/channel_err_injector_pkg.sv
// Shared definitions for the channel error injector: injection modes and LFSR constants.
package chan_inj_pkg;

   typedef enum logic [1:0] {
      INJ_OFF      = 2'd0,
      INJ_PERIODIC = 2'd1,
      INJ_BURST    = 2'd2,
      INJ_RANDOM   = 2'd3
   } inj_mode_e;

   // Feedback taps for x^16+x^14+x^13+x^11+1, bit n of the mask is register stage n+1.
   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/channel_err_injector_if.sv
// Symbol stream into and out of the error injector; master drives symbols, slave returns the channel view.
interface channel_err_injector_if #(
   parameter int SYM_W = 2
);
   logic             valid_i;
   logic [SYM_W-1:0] sym_i;
   logic             valid_o;
   logic [SYM_W-1:0] sym_o;
   logic             err_o;

   modport master (output valid_i, sym_i, input valid_o, sym_o, err_o);
   modport slave  (input valid_i, sym_i, output valid_o, sym_o, err_o);
endinterface

// File: rtl/channel_err_injector_lfsr16.sv
// 16-bit Fibonacci LFSR, shifting toward the MSB; load wins over advance.
module lfsr16
   import chan_inj_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        adv,
   input  logic        load,
   output logic [15:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= SEED;
      end else if (load) begin
         q <= SEED;
      end else if (adv) begin
         q <= {q[14:0], ^(q & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/channel_err_injector.sv
// Channel error injector: flips err_mask_i bits on selected symbols and keeps saturating statistics.
module channel_err_injector
   import chan_inj_pkg::*;
#(
   parameter int          SYM_W     = 2,
   parameter int          CNT_W     = 32,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   rst,
   channel_err_injector_if.slave  ch,
   input  logic [1:0]             mode_i,
   input  logic [3:0]             period_log2_i,
   input  logic [7:0]             burst_len_i,
   input  logic [SYM_W-1:0]       err_mask_i,
   input  logic [15:0]            threshold_i,
   input  logic [CNT_W-1:0]       window_i,
   input  logic                   clear_i,
   output logic [CNT_W-1:0]       sym_ct_o,
   output logic [CNT_W-1:0]       inj_ct_o,
   output logic [CNT_W-1:0]       bad_bit_ct_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [15:0]      lfsr_q;
   logic [15:0]      k_lo;
   logic [15:0]      k_mod;
   logic [15:0]      period_mask;
   logic [16:0]      period;
   logic             take;
   logic             eligible;
   logic             mode_hit;
   logic             inj;
   logic [CNT_W-1:0] pop;
   logic [CNT_W:0]   bad_sum;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .adv  (take),
      .load (clear_i),
      .q    (lfsr_q)
   );

   // The current symbol index is the pre-increment sym_ct, saturated value included.
   always_comb begin
      k_lo        = 16'(sym_ct_o);
      period      = 17'd1 << period_log2_i;
      period_mask = 16'(period - 17'd1);
      k_mod       = k_lo & period_mask;
      take        = ch.valid_i && !clear_i;
      eligible    = (window_i == '0) || (sym_ct_o < window_i);

      mode_hit = 1'b0;
      case (inj_mode_e'(mode_i))
         INJ_OFF:      mode_hit = 1'b0;
         INJ_PERIODIC: mode_hit = (k_mod == period_mask);
         // k mod 2^P >= 2^P - B, rearranged to avoid a negative threshold when B > 2^P
         INJ_BURST:    mode_hit = (burst_len_i != 8'd0) &&
                                  (({1'b0, k_mod} + 17'(burst_len_i)) >= period);
         INJ_RANDOM:   mode_hit = (lfsr_q < threshold_i);
         default:      mode_hit = 1'b0;
      endcase

      inj = take && eligible && mode_hit;

      pop = '0;
      for (int i = 0; i < SYM_W; i++) begin
         pop = pop + CNT_W'(err_mask_i[i]);
      end
      bad_sum = {1'b0, bad_bit_ct_o} + {1'b0, pop};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ch.valid_o   <= 1'b0;
         ch.sym_o     <= '0;
         ch.err_o     <= 1'b0;
         sym_ct_o     <= '0;
         inj_ct_o     <= '0;
         bad_bit_ct_o <= '0;
      end else begin
         ch.valid_o <= ch.valid_i;
         ch.err_o   <= inj;
         if (ch.valid_i) begin
            ch.sym_o <= ch.sym_i ^ (inj ? err_mask_i : '0);
         end

         if (clear_i) begin
            sym_ct_o     <= '0;
            inj_ct_o     <= '0;
            bad_bit_ct_o <= '0;
         end else if (take) begin
            if (sym_ct_o != CNT_MAX) begin
               sym_ct_o <= sym_ct_o + 1'b1;
            end
            if (inj) begin
               if (inj_ct_o != CNT_MAX) begin
                  inj_ct_o <= inj_ct_o + 1'b1;
               end
               bad_bit_ct_o <= bad_sum[CNT_W] ? CNT_MAX : bad_sum[CNT_W-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_channel_err_injector.sv
// Bench for channel_err_injector: spec-level model compared every cycle, plus directed literal checks.
module tb_channel_err_injector;

   localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;

   logic        clk;
   logic        rst;
   logic [1:0]  mode;
   logic [3:0]  p;
   logic [7:0]  b;
   logic [1:0]  mask;
   logic [15:0] thr;
   logic [31:0] win;
   logic        clr;
   logic [31:0] sym_ct, inj_ct, bad_ct;
   logic [3:0]  b_sym_ct, b_inj_ct, b_bad_ct;

   channel_err_injector_if #(.SYM_W(2)) ifa ();
   channel_err_injector_if #(.SYM_W(2)) ifb ();

   channel_err_injector #(.SYM_W(2), .CNT_W(32), .LFSR_SEED(16'hACE1)) dut (
      .clk(clk), .rst(rst), .ch(ifa),
      .mode_i(mode), .period_log2_i(p), .burst_len_i(b), .err_mask_i(mask),
      .threshold_i(thr), .window_i(win), .clear_i(clr),
      .sym_ct_o(sym_ct), .inj_ct_o(inj_ct), .bad_bit_ct_o(bad_ct)
   );

   channel_err_injector #(.SYM_W(2), .CNT_W(4), .LFSR_SEED(16'hACE1)) dut_b (
      .clk(clk), .rst(rst), .ch(ifb),
      .mode_i(2'd0), .period_log2_i(4'd0), .burst_len_i(8'd0), .err_mask_i(2'b11),
      .threshold_i(16'd0), .window_i(4'd0), .clear_i(1'b0),
      .sym_ct_o(b_sym_ct), .inj_ct_o(b_inj_ct), .bad_bit_ct_o(b_bad_ct)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural model ----------------
   longint     m_sym_ct, m_inj_ct, m_bad;
   bit [15:0]  m_lfsr;
   bit         m_valid, m_err;
   bit [1:0]   m_sym;
   bit         rec_on, rep_on, rep_chk, rep_exp;
   bit         rec_q[$];
   int         rep_idx;
   int         n_err;

   function automatic bit [15:0] lfsr_next(input bit [15:0] s);
      bit fb;
      fb = s[15] ^ s[13] ^ s[12] ^ s[10];
      return {s[14:0], fb};
   endfunction

   function automatic bit inj_rule(input longint k, input int md, input int pe, input int bl,
                                   input bit [15:0] lf, input int th, input longint w);
      longint per, r;
      if (!(w == 0 || k < w)) return 1'b0;
      per = longint'(1) << pe;
      r   = k % per;
      case (md)
         1:       return r == per - 1;
         2:       return r >= per - longint'(bl);
         3:       return int'(lf) < th;
         default: return 1'b0;
      endcase
   endfunction

   always @(posedge clk) begin
      bit inj;
      rep_chk = 1'b0;
      if (!rst) begin
         m_valid = 0; m_sym = 0; m_err = 0;
         m_sym_ct = 0; m_inj_ct = 0; m_bad = 0; m_lfsr = 16'hACE1;
      end else if (clr) begin
         m_valid = ifa.valid_i;
         if (ifa.valid_i) m_sym = ifa.sym_i;
         m_err = 0;
         m_sym_ct = 0; m_inj_ct = 0; m_bad = 0; m_lfsr = 16'hACE1;
      end else if (ifa.valid_i) begin
         inj = inj_rule(m_sym_ct, int'(mode), int'(p), int'(b), m_lfsr, int'(thr), longint'(win));
         m_valid = 1;
         m_sym   = ifa.sym_i ^ (inj ? mask : 2'b00);
         m_err   = inj;
         m_sym_ct = (m_sym_ct == MAX32) ? MAX32 : m_sym_ct + 1;
         if (inj) begin
            m_inj_ct = (m_inj_ct == MAX32) ? MAX32 : m_inj_ct + 1;
            m_bad    = (m_bad + $countones(mask) > MAX32) ? MAX32 : m_bad + $countones(mask);
         end
         m_lfsr = lfsr_next(m_lfsr);
         if (rec_on) rec_q.push_back(inj);
         if (rep_on) begin
            rep_chk = 1'b1;
            rep_exp = (rep_idx < rec_q.size()) ? rec_q[rep_idx] : ~inj;
            rep_idx++;
         end
      end else begin
         m_valid = 0;
         m_err   = 0;
      end
      #1;
      chk("valid_o", ifa.valid_o, m_valid);
      chk("sym_o", ifa.sym_o, m_sym);
      chk("err_o", ifa.err_o, m_err);
      chk("sym_ct", sym_ct, m_sym_ct);
      chk("inj_ct", inj_ct, m_inj_ct);
      chk("bad_bit_ct", bad_ct, m_bad);
      if (rep_chk) chk("replay_err", ifa.err_o, rep_exp);
      if (ifa.err_o) n_err++;
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit v, input bit [1:0] s);
      @(negedge clk);
      ifa.valid_i = v;
      ifa.sym_i   = s;
   endtask

   task automatic do_clear();
      @(negedge clk);
      clr = 1'b1;
      ifa.valid_i = 1'b0;
      @(negedge clk);
      clr = 1'b0;
   endtask

   initial begin
      rst = 1'b0; clr = 1'b0;
      mode = 2'd0; p = 4'd0; b = 8'd0; mask = 2'b00; thr = 16'd0; win = 32'd0;
      ifa.valid_i = 1'b0; ifa.sym_i = 2'b00;
      ifb.valid_i = 1'b0; ifb.sym_i = 2'b00;
      rec_on = 0; rep_on = 0; rep_idx = 0; n_err = 0;

      repeat (3) @(negedge clk);
      chk("reset_valid_o", ifa.valid_o, 0);
      chk("reset_sym_ct", sym_ct, 0);
      chk("model_lfsr_step", lfsr_next(16'hACE1), 16'h59C3);
      rst = 1'b1;

      // periodic P=3, window 256, 300 symbols
      mode = 2'd1; p = 4'd3; mask = 2'b01; win = 32'd256; n_err = 0;
      for (int i = 0; i < 300; i++) drive(1'b1, 2'(i));
      drive(1'b0, 2'b00);
      chk("per_sym_ct", sym_ct, 300);
      chk("per_inj_ct", inj_ct, 32);
      chk("per_bad_ct", bad_ct, 32);
      chk("per_err_count", n_err, 32);

      // burst P=4, B=3, 64 symbols
      do_clear();
      mode = 2'd2; p = 4'd4; b = 8'd3; mask = 2'b11; win = 32'd0;
      for (int i = 0; i < 64; i++) drive(1'b1, 2'(i + 1));
      drive(1'b0, 2'b00);
      chk("burst_inj_ct", inj_ct, 12);
      chk("burst_bad_ct", bad_ct, 24);

      // random threshold 0, then 0xFFFF
      do_clear();
      mode = 2'd3; thr = 16'h0000; mask = 2'b10;
      for (int i = 0; i < 1000; i++) drive(1'b1, 2'(i));
      drive(1'b0, 2'b00);
      chk("rand0_inj_ct", inj_ct, 0);
      do_clear();
      thr = 16'hFFFF;
      for (int i = 0; i < 1000; i++) drive(1'b1, 2'(i));
      drive(1'b0, 2'b00);
      chk("randffff_inj_ge_998", (inj_ct >= 998) ? 1 : 0, 1);

      // reproducibility from the seed after clear
      do_clear();
      thr = 16'h8000; rec_on = 1;
      for (int i = 0; i < 200; i++) drive(1'b1, 2'(i));
      drive(1'b0, 2'b00);
      rec_on = 0;
      do_clear();
      rep_on = 1;
      for (int i = 0; i < 200; i++) drive(1'b1, 2'(i));
      drive(1'b0, 2'b00);
      rep_on = 0;
      chk("replay_len", rep_idx, 200);

      // gapped valid, periodic P=1
      do_clear();
      mode = 2'd1; p = 4'd1; mask = 2'b10;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 2'(i));
         drive(1'b0, 2'b00);
         drive(1'b0, 2'b11);
      end
      chk("gap_sym_ct", sym_ct, 10);
      chk("gap_inj_ct", inj_ct, 5);

      // clear coincident with a valid symbol at k=5
      do_clear();
      mode = 2'd1; p = 4'd0; mask = 2'b11;
      for (int i = 0; i < 5; i++) drive(1'b1, 2'b00);
      @(negedge clk);
      clr = 1'b1; ifa.valid_i = 1'b1; ifa.sym_i = 2'b01;
      @(negedge clk);
      chk("clr_sym_clean", ifa.sym_o, 2'b01);
      chk("clr_err_low", ifa.err_o, 0);
      chk("clr_sym_ct", sym_ct, 0);
      clr = 1'b0; mode = 2'd3; thr = 16'hACE2; ifa.sym_i = 2'b00;
      @(negedge clk);
      chk("seed_inj", ifa.err_o, 1);
      chk("after_clr_sym_ct", sym_ct, 1);
      thr = 16'h59C3;
      @(negedge clk);
      chk("step_no_inj", ifa.err_o, 0);
      ifa.valid_i = 1'b0;

      // CNT_W=4 saturation
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         ifb.valid_i = 1'b1; ifb.sym_i = 2'(i);
      end
      @(negedge clk);
      ifb.valid_i = 1'b0;
      @(negedge clk);
      chk("sat_sym_ct", b_sym_ct, 15);
      chk("sat_inj_ct", b_inj_ct, 0);

      // asynchronous reset mid-stream
      mode = 2'd1; p = 4'd0; mask = 2'b11;
      for (int i = 0; i < 3; i++) drive(1'b1, 2'b01);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("arst_valid_o", ifa.valid_o, 0);
      chk("arst_sym_o", ifa.sym_o, 0);
      chk("arst_err_o", ifa.err_o, 0);
      chk("arst_sym_ct", sym_ct, 0);
      chk("arst_inj_ct", inj_ct, 0);
      chk("arst_b_sym_ct", b_sym_ct, 0);
      @(negedge clk);
      ifa.valid_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) drive(1'b1, 2'b01);
      drive(1'b0, 2'b00);
      chk("post_rst_sym_ct", sym_ct, 3);
      chk("post_rst_inj_ct", inj_ct, 3);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
